prod_accumulator: RTL and testbench
===================================

Name: prod_accumulator

Overview:
- Sequential stage directly downstream of the 4x3 combinational multiplier (X[3:0] x Y[2:0] -> P[6:0]).
- Accepts one 7-bit product per valid/ready handshake and sums N products into one frame result.
- Presents the frame result on a valid/ready output with a sticky overflow flag.
- Turns the bare multiplier into a dot-product / MAC datapath.

Parameters:
- PW, 7, product input width; matches multiplier P.
- N, 4, products per frame; N >= 2.
- AW, 10, accumulator/SUM width; AW >= PW.
- CW, $clog2(N), frame counter width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  synchronous active-low reset.
- P  input  PW  product from the multiplier, unsigned.
- P_VALID  input  1  P is valid this cycle.
- P_READY  output  1  block accepts P this cycle.
- CLR  input  1  synchronous frame abort.
- SUM  output  AW  frame sum, valid when SUM_VALID=1.
- SUM_VALID  output  1  frame result available.
- SUM_READY  input  1  consumer takes SUM.
- OVF  output  1  frame sum wrapped modulo 2^AW; qualified by SUM_VALID.
- CNT  output  CW  number of products accepted in the current frame.

Behaviour:
- Interface: one clock CLK; reset RST_N is synchronous and active-low. Only rising edges of CLK change state; RST_N is sampled on them.
- Reset (RST_N=0 at an edge):
  - state=ACC; acc=0; CNT=0; SUM=0; SUM_VALID=0; OVF=0.
  - P_READY=1 from the first cycle after reset.
- Priority order: RST_N, then CLR, then handshakes.
- State ACC:
  - P_READY=1 and SUM_VALID=0.
  - Accept occurs when P_VALID=1. On accept, P is zero-extended to AW+1 bits and added to acc.
  - acc takes the low AW bits; a carry out sets an internal sticky ovf.
  - CNT increments on each accept.
  - Accept with CNT<N-1: stay in ACC.
  - Accept with CNT==N-1: go to HOLD. SUM <= acc+P (mod 2^AW); OVF <= ovf | carry; SUM_VALID=1 from the next cycle.
  - Latency: SUM_VALID rises one cycle after the Nth accept.
- State HOLD:
  - P_READY=0; P and P_VALID are ignored; SUM and OVF are held stable.
  - SUM_VALID stays high until SUM_READY=1 at an edge.
  - On that edge: go to ACC, acc=0, CNT=0, ovf=0, SUM_VALID=0. SUM keeps its last value.
  - No product is accepted on the handoff edge. Frame throughput is at most N products per N+1 cycles.
- CLR=1 at an edge, any state:
  - state=ACC; acc=0; CNT=0; ovf=0; SUM_VALID=0.
  - Any in-flight P is discarded, even if P_VALID=1 that cycle.
  - SUM and OVF registers keep their old values; they are unqualified because SUM_VALID=0.
- Wrap-around:
  - CNT goes N-1 -> 0 via the HOLD exit, never by overflow.
  - acc wraps mod 2^AW with OVF set.
  - With defaults the maximum sum is 4*105=420 < 1024, so OVF never fires.
- Outputs are registered: P_READY, SUM_VALID and CNT are derived from state/registers only, with no combinational path from inputs.
- P=0 is a legal product; it counts toward N.

Decomposition:
- Package prod_acc_pkg:
  - state_t enum {ACC, HOLD} (logic, 1 bit).
  - Localparams: PW_DEF=7, N_DEF=4, AW_DEF=10.
  - Constant P_MAX=105 for benches.
- Single module, no sub-module. The counter and adder are small enough to stay inline.
- Top-level integration instantiates MUL43 and drives P from it. P_VALID comes from the upstream operand register.

Test Plan:
- Reset then products 1,3,21,5 with P_VALID=1 for 4 consecutive cycles -> SUM=30 (10'b0000011110), SUM_VALID=1 one cycle after the 4th accept, OVF=0, CNT steps 0,1,2,3,0.
- Max-value frame: four products of 105 -> SUM=420, OVF=0. Then hold SUM_READY=0 for 5 cycles -> SUM/SUM_VALID stable, P_READY=0, and P_VALID pulses are ignored.
- Overflow with AW=8 override: four products of 105 -> SUM=164 (420-256), OVF=1. Next frame 1,1,1,1 -> SUM=4, OVF=0 (sticky cleared per frame).
- Gapped input: P_VALID toggling 1,0,1,0,... with products 7,14,0,35 -> SUM=56 after the 4th accept; the P value during P_VALID=0 cycles is ignored.
- CLR after 2 accepts (7,9), then products 2,2,2,2 -> SUM=8, not 24.
- RST_N=0 for one edge while in HOLD -> SUM_VALID=0, SUM=0, CNT=0, P_READY=1 on the next cycle.

Source files
------------

// File: rtl/prod_acc_pkg.sv
// Shared types and defaults for the product accumulator that sits behind the
// 4x3 multiplier.
package prod_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int PW_DEF = 7;
    localparam int N_DEF  = 4;
    localparam int AW_DEF = 10;

    // Largest product the 4x3 multiplier can emit (15 * 7).
    localparam int P_MAX  = 105;

endpackage

// File: rtl/prod_accumulator.sv
// Sums N unsigned products per frame and presents the result on a valid/ready
// output with a sticky wrap flag. One frame result is held until consumed.
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [PW-1:0] P,
    input  logic          P_VALID,
    output logic          P_READY,
    input  logic          CLR,
    output logic [AW-1:0] SUM,
    output logic          SUM_VALID,
    input  logic          SUM_READY,
    output logic          OVF,
    output logic [CW-1:0] CNT
);

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] sum_q, sum_d;
    logic          ovfo_q, ovfo_d;

    logic [AW:0]   add;
    logic          carry;

    assign add   = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, P};
    assign carry = add[AW];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ovfo_d  = ovfo_q;
        if (CLR) begin
            // Abort drops the frame; the last published SUM/OVF stay as-is.
            state_d = ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (P_VALID) begin
                        acc_d = add[AW-1:0];
                        ovf_d = ovf_q | carry;
                        if (cnt_q == CW'(N - 1)) begin
                            // CNT parks at N-1 while holding; it clears on the handoff.
                            state_d = HOLD;
                            sum_d   = add[AW-1:0];
                            ovfo_d  = ovf_q | carry;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (SUM_READY) begin
                        state_d = ACC;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ovfo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ovfo_q  <= ovfo_d;
        end
    end

    assign P_READY   = (state_q == ACC);
    assign SUM_VALID = (state_q == HOLD);
    assign SUM       = sum_q;
    assign OVF       = ovfo_q;
    assign CNT       = cnt_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Drives a default (AW=10) and a narrow (AW=8) accumulator with one shared
// stimulus stream and checks both against a frame-level model every cycle.
module tb_prod_accumulator;
    import prod_acc_pkg::*;

    localparam int PW = 7;
    localparam int N  = 4;
    localparam int CW = 2;

    logic          CLK;
    logic          RST_N;
    logic [PW-1:0] P;
    logic          P_VALID;
    logic          CLR;
    logic          SUM_READY;

    logic          a_p_ready, a_sum_valid, a_ovf;
    logic [9:0]    a_sum;
    logic [CW-1:0] a_cnt;
    logic          b_p_ready, b_sum_valid, b_ovf;
    logic [7:0]    b_sum;
    logic [CW-1:0] b_cnt;

    int n_checks = 0;
    int n_errs   = 0;
    logic chk_en = 1'b0;

    prod_accumulator #(.PW(PW), .N(N), .AW(10)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .P(P), .P_VALID(P_VALID), .P_READY(a_p_ready),
        .CLR(CLR), .SUM(a_sum), .SUM_VALID(a_sum_valid), .SUM_READY(SUM_READY),
        .OVF(a_ovf), .CNT(a_cnt)
    );

    prod_accumulator #(.PW(PW), .N(N), .AW(8)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .P(P), .P_VALID(P_VALID), .P_READY(b_p_ready),
        .CLR(CLR), .SUM(b_sum), .SUM_VALID(b_sum_valid), .SUM_READY(SUM_READY),
        .OVF(b_ovf), .CNT(b_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Frame-level model: running total of accepted products, a holding flag,
    // and the published result reduced modulo 2^AW for each width.
    logic m_hold = 1'b0;
    int   m_cnt = 0;
    int   m_total = 0;
    int   m_sum [2];
    logic m_ovf [2];
    int   aws [2] = '{10, 8};

    always @(posedge CLK) begin
        logic h;
        int   c, t;
        h = m_hold;
        c = m_cnt;
        t = m_total;
        if (!RST_N) begin
            h = 1'b0; c = 0; t = 0;
            for (int k = 0; k < 2; k++) begin
                m_sum[k] <= 0;
                m_ovf[k] <= 1'b0;
            end
        end else if (CLR) begin
            h = 1'b0; c = 0; t = 0;
        end else if (h) begin
            if (SUM_READY) begin
                h = 1'b0; c = 0; t = 0;
            end
        end else if (P_VALID) begin
            t = t + int'(P);
            c = c + 1;
            if (c == N) begin
                h = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    m_sum[k] <= t % (1 << aws[k]);
                    m_ovf[k] <= (t >= (1 << aws[k]));
                end
            end
        end
        m_hold  <= h;
        m_cnt   <= c;
        m_total <= t;
    end

    // Compare process: outputs are registered, so they are stable at the falling edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("a_p_ready",   int'(a_p_ready),   int'(!m_hold));
            chk("a_sum_valid", int'(a_sum_valid), int'(m_hold));
            chk("a_cnt",       int'(a_cnt),       m_hold ? N - 1 : m_cnt);
            chk("a_sum",       int'(a_sum),       m_sum[0]);
            chk("a_ovf",       int'(a_ovf),       int'(m_ovf[0]));
            chk("b_p_ready",   int'(b_p_ready),   int'(!m_hold));
            chk("b_sum_valid", int'(b_sum_valid), int'(m_hold));
            chk("b_cnt",       int'(b_cnt),       m_hold ? N - 1 : m_cnt);
            chk("b_sum",       int'(b_sum),       m_sum[1]);
            chk("b_ovf",       int'(b_ovf),       int'(m_ovf[1]));
        end
    end

    // Apply inputs for one rising edge; returns at the following falling edge.
    task automatic drive(input int p, input logic v, input logic c, input logic r,
                         input logic rst = 1'b1);
        P         = PW'(p);
        P_VALID   = v;
        CLR       = c;
        SUM_READY = r;
        RST_N     = rst;
        @(negedge CLK);
    endtask

    int f1 [4] = '{1, 3, 21, 5};

    initial begin
        P = '0; P_VALID = 1'b0; CLR = 1'b0; SUM_READY = 1'b0; RST_N = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("lit_rst_sum_valid", int'(a_sum_valid), 0);
        chk("lit_rst_p_ready", int'(a_p_ready), 1);
        chk("lit_rst_sum", int'(a_sum), 0);

        // Basic frame; SUM_READY low so the result is held.
        for (int i = 0; i < 4; i++) begin
            chk("lit_cnt_step", int'(a_cnt), i);
            drive(f1[i], 1, 0, 0);
        end
        chk("lit_f1_sum", int'(a_sum), 30);
        chk("lit_f1_valid", int'(a_sum_valid), 1);
        chk("lit_f1_ovf", int'(a_ovf), 0);
        drive(0, 0, 0, 1);
        chk("lit_f1_cnt_after", int'(a_cnt), 0);
        chk("lit_f1_sum_kept", int'(a_sum), 30);

        // Max-value frame, then a long hold with stray P_VALID pulses.
        for (int i = 0; i < 4; i++) drive(P_MAX, 1, 0, 0);
        for (int i = 0; i < 5; i++) drive(50, (i % 2) == 0, 0, 0);
        chk("lit_max_sum_a", int'(a_sum), 420);
        chk("lit_max_ovf_a", int'(a_ovf), 0);
        chk("lit_max_sum_b", int'(b_sum), 164);
        chk("lit_max_ovf_b", int'(b_ovf), 1);
        chk("lit_max_p_ready", int'(a_p_ready), 0);
        drive(0, 0, 0, 1);

        // Sticky overflow clears per frame.
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
        chk("lit_ones_sum_b", int'(b_sum), 4);
        chk("lit_ones_ovf_b", int'(b_ovf), 0);
        drive(0, 0, 0, 1);

        // Gapped input with garbage on idle cycles; SUM_READY stays high throughout.
        drive(7, 1, 0, 1);  drive(99, 0, 0, 1);
        drive(14, 1, 0, 1); drive(99, 0, 0, 1);
        drive(0, 1, 0, 1);  drive(99, 0, 0, 1);
        drive(35, 1, 0, 1);
        chk("lit_gap_sum", int'(a_sum), 56);
        chk("lit_gap_valid", int'(a_sum_valid), 1);
        drive(99, 1, 0, 1);
        chk("lit_gap_handoff", int'(a_sum_valid), 0);
        chk("lit_gap_no_accept", int'(a_cnt), 0);

        // Abort mid-frame, with a valid product on the CLR edge that must be dropped.
        drive(7, 1, 0, 0);
        drive(9, 1, 0, 0);
        drive(5, 1, 1, 0);
        chk("lit_clr_cnt", int'(a_cnt), 0);
        for (int i = 0; i < 4; i++) drive(2, 1, 0, 0);
        chk("lit_clr_sum", int'(a_sum), 8);

        // Reset while holding.
        drive(0, 0, 0, 0, 0);
        chk("lit_rst_hold_valid", int'(a_sum_valid), 0);
        chk("lit_rst_hold_sum", int'(a_sum), 0);
        chk("lit_rst_hold_cnt", int'(a_cnt), 0);
        chk("lit_rst_hold_ready", int'(a_p_ready), 1);
        drive(3, 1, 0, 0);
        drive(0, 0, 0, 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
